// File: rtl/sb_pkg.sv
// Shared sideband definitions: arbiter state/requester enums, SB symbol codes
// and small helpers used by the TX arbiter and the RX decoder.
package sb_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
   typedef enum logic [1:0] {REQ_LT, REQ_RSP, REQ_CMD, REQ_NONE} req_t;

   localparam logic [7:0] DLE     = 8'h10;
   localparam logic [7:0] STX_CMD = 8'h02;
   localparam logic [7:0] STX_RSP = 8'h03;
   localparam logic [7:0] ETX     = 8'h04;
   localparam logic [7:0] LSE     = 8'h05;
   localparam logic [7:0] CLSE    = 8'h06;

   // Counter width able to hold max_val; never narrower than one bit.
   function automatic int cnt_w(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

   // Fixed priority LT > RSP > CMD, unless the command is pushed to the front.
   function automatic req_t arb_pick(input logic lt, input logic rsp,
                                     input logic cmd, input logic cmd_first);
      if (cmd_first && cmd) return REQ_CMD;
      if (lt)               return REQ_LT;
      if (rsp)              return REQ_RSP;
      if (cmd)              return REQ_CMD;
      return REQ_NONE;
   endfunction

endpackage

// File: rtl/sb_cmd_tracker.sv
// Tracks the single outstanding AT command: response timeout, retry counting
// and the cmd_ok / cmd_retry / cmd_fail pulses.
module sb_cmd_tracker
   import sb_pkg::*;
#(
   parameter int RSP_TIMEOUT = 1000,
   parameter int MAX_RETRY   = 3
) (
   input  logic sb_clk,
   input  logic rst,
   input  logic disconnect,
   input  logic cmd_done,
   input  logic rsp_rcvd,
   output logic outstanding,
   output logic outstanding_nxt,
   output logic retry_pend,
   output logic cmd_ok,
   output logic cmd_retry,
   output logic cmd_fail
);

   localparam int TMR_W = cnt_w(RSP_TIMEOUT);
   localparam int RTY_W = cnt_w(MAX_RETRY);

   logic             outst_q, outst_d;
   logic             pend_q, pend_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
   logic             ok_q, ok_d;
   logic             retry_q, retry_d;
   logic             fail_q, fail_d;

   always_comb begin
      outst_d     = outst_q;
      pend_d      = pend_q;
      timer_d     = timer_q;
      retry_cnt_d = retry_cnt_q;
      ok_d        = 1'b0;
      retry_d     = 1'b0;
      fail_d      = 1'b0;
      if (disconnect) begin
         // Link loss abandons the command silently.
         outst_d     = 1'b0;
         pend_d      = 1'b0;
         timer_d     = '0;
         retry_cnt_d = '0;
      end else begin
         if (outst_q) begin
            if (rsp_rcvd) begin
               ok_d        = 1'b1;
               outst_d     = 1'b0;
               retry_cnt_d = '0;
            end else if (timer_q == TMR_W'(1)) begin
               outst_d = 1'b0;
               if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
                  retry_cnt_d = retry_cnt_q + 1'b1;
                  retry_d     = 1'b1;
                  pend_d      = 1'b1;
               end else begin
                  fail_d      = 1'b1;
                  retry_cnt_d = '0;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         if (cmd_done) begin
            outst_d = 1'b1;
            timer_d = TMR_W'(RSP_TIMEOUT);
            pend_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         outst_q     <= 1'b0;
         pend_q      <= 1'b0;
         timer_q     <= '0;
         retry_cnt_q <= '0;
         ok_q        <= 1'b0;
         retry_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         outst_q     <= outst_d;
         pend_q      <= pend_d;
         timer_q     <= timer_d;
         retry_cnt_q <= retry_cnt_d;
         ok_q        <= ok_d;
         retry_q     <= retry_d;
         fail_q      <= fail_d;
      end
   end

   assign outstanding     = outst_q;
   assign outstanding_nxt = outst_d;
   assign retry_pend      = pend_q;
   assign cmd_ok          = ok_q;
   assign cmd_retry       = retry_q;
   assign cmd_fail        = fail_q;

endmodule

// File: rtl/sb_tx_arbiter.sv
// Sideband TX framer arbiter (LT > RSP > CMD) with inter-frame gap and AT
// command tracking. Define SB_ARB_STARVE_GUARD_EN to enable the CMD starvation guard.
module sb_tx_arbiter
   import sb_pkg::*;
#(
   parameter int GAP_CYCLES   = 4,
   parameter int RSP_TIMEOUT  = 1000,
   parameter int MAX_RETRY    = 3,
   parameter int STARVE_LIMIT = 8
) (
   input  logic sb_clk,
   input  logic rst,
   input  logic disconnect,
   input  logic lt_req,
   input  logic at_rsp_req,
   input  logic at_cmd_req,
   input  logic tx_done,
   input  logic rsp_rcvd,
   output logic lt_gnt,
   output logic rsp_gnt,
   output logic cmd_gnt,
   output logic tx_start,
   output logic cmd_ok,
   output logic cmd_retry,
   output logic cmd_fail,
   output logic busy
);

   localparam int GAP_W = cnt_w(GAP_CYCLES);

   arb_state_t       state_q, state_d;
   logic [2:0]       gnt_q, gnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             tx_start_q, tx_start_d;
   logic             busy_q, busy_d;

   logic outstanding, outstanding_nxt, retry_pend;
   logic cmd_elig, cmd_first, cmd_done, arb_fire;
   req_t pick;

   assign cmd_elig = (at_cmd_req | retry_pend) & ~outstanding;
   assign cmd_done = (state_q == GRANT) & gnt_q[2] & tx_done;
   assign pick     = arb_pick(lt_req, at_rsp_req, cmd_elig, cmd_first);
   assign arb_fire = (state_q == IDLE) & ~disconnect & (pick != REQ_NONE);

`ifdef SB_ARB_STARVE_GUARD_EN
   localparam int STV_W = cnt_w(STARVE_LIMIT);

   logic [STV_W-1:0] starve_q, starve_d;

   assign cmd_first = (starve_q >= STV_W'(STARVE_LIMIT));

   // Counts LT/RSP wins taken while a command was ready to go.
   always_comb begin
      starve_d = starve_q;
      if (disconnect) begin
         starve_d = '0;
      end else if (arb_fire) begin
         if (pick == REQ_CMD) begin
            starve_d = '0;
         end else if (cmd_elig && (starve_q < STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) starve_q <= '0;
      else      starve_q <= starve_d;
   end
`else
   assign cmd_first = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gap_d      = gap_q;
      tx_start_d = 1'b0;
      if (disconnect) begin
         state_d = IDLE;
         gnt_d   = '0;
         gap_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_fire) begin
                  state_d    = GRANT;
                  gnt_d      = 3'b001 << pick;
                  tx_start_d = 1'b1;
               end
            end
            GRANT: begin
               if (tx_done) begin
                  gnt_d = '0;
                  if (GAP_CYCLES == 0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = GAP;
                     gap_d   = GAP_W'(GAP_CYCLES);
                  end
               end
            end
            GAP: begin
               if (gap_q <= GAP_W'(1)) state_d = IDLE;
               else                     gap_d   = gap_q - 1'b1;
            end
            default: begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         endcase
      end
      busy_d = (state_d != IDLE) | outstanding_nxt;
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         gap_q      <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gap_q      <= gap_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
      end
   end

   sb_cmd_tracker #(
      .RSP_TIMEOUT (RSP_TIMEOUT),
      .MAX_RETRY   (MAX_RETRY)
   ) u_cmd_tracker (
      .sb_clk          (sb_clk),
      .rst             (rst),
      .disconnect      (disconnect),
      .cmd_done        (cmd_done),
      .rsp_rcvd        (rsp_rcvd),
      .outstanding     (outstanding),
      .outstanding_nxt (outstanding_nxt),
      .retry_pend      (retry_pend),
      .cmd_ok          (cmd_ok),
      .cmd_retry       (cmd_retry),
      .cmd_fail        (cmd_fail)
   );

   assign lt_gnt   = gnt_q[0];
   assign rsp_gnt  = gnt_q[1];
   assign cmd_gnt  = gnt_q[2];
   assign tx_start = tx_start_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Bench for sb_tx_arbiter: directed vector table, corner-case sequences and a
// randomized run against a timestamp-based reference model.
module tb_sb_tx_arbiter;

   localparam int GAP  = 4;
   localparam int TMO  = 40;
   localparam int MAXR = 1;
   localparam int SLIM = 2;
`ifdef SB_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic sb_clk = 1'b0;
   logic rst = 1'b0;
   logic disconnect = 1'b0;
   logic lt_req = 1'b0, at_rsp_req = 1'b0, at_cmd_req = 1'b0;
   logic tx_done = 1'b0, rsp_rcvd = 1'b0;
   logic lt_gnt, rsp_gnt, cmd_gnt, tx_start, cmd_ok, cmd_retry, cmd_fail, busy;

   always #5 sb_clk = ~sb_clk;

   sb_tx_arbiter #(
      .GAP_CYCLES   (GAP),
      .RSP_TIMEOUT  (TMO),
      .MAX_RETRY    (MAXR),
      .STARVE_LIMIT (SLIM)
   ) dut (
      .sb_clk     (sb_clk),
      .rst        (rst),
      .disconnect (disconnect),
      .lt_req     (lt_req),
      .at_rsp_req (at_rsp_req),
      .at_cmd_req (at_cmd_req),
      .tx_done    (tx_done),
      .rsp_rcvd   (rsp_rcvd),
      .lt_gnt     (lt_gnt),
      .rsp_gnt    (rsp_gnt),
      .cmd_gnt    (cmd_gnt),
      .tx_start   (tx_start),
      .cmd_ok     (cmd_ok),
      .cmd_retry  (cmd_retry),
      .cmd_fail   (cmd_fail),
      .busy       (busy)
   );

   int n_chk = 0, n_fail = 0, cyc = 0;

   // Reference model: owner 0=none 1=LT 2=RSP 3=CMD; times are absolute cycles.
   int m_owner = 0, m_free = 0, m_dead = 0, m_retries = 0, m_starve = 0;
   bit m_outst = 0, m_pend = 0;
   bit e_lt, e_rsp, e_cmd, e_ts, e_ok, e_rty, e_fail, e_busy;

   int cnt_cmd = 0, cnt_ok = 0, cnt_rty = 0, cnt_fail = 0, n_grants = 0, first_cmd = -1;

   typedef struct {
      bit lt, rsp, cmd, done;
      bit lt_g, rsp_g, cmd_g, ts, bsy;
   } vec_t;
   vec_t tbl[13];

   task automatic check(input string name, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 60)
            $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   task automatic model_step();
      int c;
      int pk;
      bit celig, cdone;
      c = cyc;
      cdone = 1'b0;
      e_ts = 0; e_ok = 0; e_rty = 0; e_fail = 0;
      if (disconnect) begin
         m_owner = 0; m_free = c + 1; m_outst = 0; m_pend = 0; m_retries = 0; m_starve = 0;
      end else begin
         celig = (at_cmd_req || m_pend) && !m_outst;
         if (m_owner != 0) begin
            if (tx_done) begin
               cdone = (m_owner == 3);
               m_owner = 0;
               m_free = c + 1 + GAP;
            end
         end else if (c >= m_free) begin
            pk = 0;
            if (GUARD && m_starve >= SLIM && celig) pk = 3;
            else if (lt_req)     pk = 1;
            else if (at_rsp_req) pk = 2;
            else if (celig)      pk = 3;
            if (pk != 0) begin
               m_owner = pk;
               e_ts = 1;
               if (GUARD) begin
                  if (pk == 3)    m_starve = 0;
                  else if (celig) m_starve++;
               end
            end
         end
         if (m_outst) begin
            if (rsp_rcvd) begin
               e_ok = 1; m_outst = 0; m_retries = 0;
            end else if (c == m_dead) begin
               m_outst = 0;
               if (m_retries < MAXR) begin
                  m_retries++; e_rty = 1; m_pend = 1;
               end else begin
                  e_fail = 1; m_retries = 0;
               end
            end
         end
         if (cdone) begin
            m_outst = 1; m_dead = c + TMO; m_pend = 0;
         end
      end
      e_lt  = (m_owner == 1);
      e_rsp = (m_owner == 2);
      e_cmd = (m_owner == 3);
      e_busy = (m_owner != 0) || (c + 1 < m_free) || m_outst;
   endtask

   task automatic tick();
      @(posedge sb_clk);
      model_step();
      cyc++;
      #1;
      check("lt_gnt", lt_gnt, e_lt);
      check("rsp_gnt", rsp_gnt, e_rsp);
      check("cmd_gnt", cmd_gnt, e_cmd);
      check("tx_start", tx_start, e_ts);
      check("cmd_ok", cmd_ok, e_ok);
      check("cmd_retry", cmd_retry, e_rty);
      check("cmd_fail", cmd_fail, e_fail);
      check("busy", busy, e_busy);
      if (tx_start) begin
         if (cmd_gnt) begin
            cnt_cmd++;
            if (first_cmd < 0) first_cmd = n_grants;
         end
         n_grants++;
      end
      cnt_ok   += int'(cmd_ok);
      cnt_rty  += int'(cmd_retry);
      cnt_fail += int'(cmd_fail);
   endtask

   task automatic clear_tally();
      cnt_cmd = 0; cnt_ok = 0; cnt_rty = 0; cnt_fail = 0; n_grants = 0; first_cmd = -1;
   endtask

   // Framer stand-in: every frame lasts two cycles.
   task automatic run_auto(input int n);
      for (int k = 0; k < n; k++) begin
         tx_done = (lt_gnt | rsp_gnt | cmd_gnt) & ~tx_start;
         tick();
      end
      tx_done = 1'b0;
   endtask

   task automatic wait_gnt(input string name, input bit want_cmd, input int lim);
      int k;
      k = 0;
      while (!(want_cmd ? cmd_gnt : lt_gnt) && k < lim) begin
         tick();
         k++;
      end
      check(name, want_cmd ? cmd_gnt : lt_gnt, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1,1,1,0, 1,0,0,1,1};
      tbl[1]  = '{1,1,1,0, 1,0,0,0,1};
      tbl[2]  = '{1,1,1,0, 1,0,0,0,1};
      tbl[3]  = '{1,1,1,0, 1,0,0,0,1};
      tbl[4]  = '{1,1,1,0, 1,0,0,0,1};
      tbl[5]  = '{1,1,1,1, 0,0,0,0,1};
      tbl[6]  = '{0,1,1,0, 0,0,0,0,1};
      tbl[7]  = '{0,1,1,0, 0,0,0,0,1};
      tbl[8]  = '{0,1,1,0, 0,0,0,0,1};
      tbl[9]  = '{0,1,1,0, 0,0,0,0,0};
      tbl[10] = '{0,1,1,0, 0,1,0,1,1};
      tbl[11] = '{0,1,1,0, 0,1,0,0,1};
      tbl[12] = '{0,1,1,1, 0,0,0,0,1};

      // Reset state
      repeat (2) @(posedge sb_clk);
      #1;
      check("rst_lt_gnt", lt_gnt, 1'b0);
      check("rst_rsp_gnt", rsp_gnt, 1'b0);
      check("rst_cmd_gnt", cmd_gnt, 1'b0);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_cmd_ok", cmd_ok, 1'b0);
      check("rst_cmd_retry", cmd_retry, 1'b0);
      check("rst_cmd_fail", cmd_fail, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b1;

      // Priority, hold-until-done and gap timing
      for (int i = 0; i < 13; i++) begin
         lt_req = tbl[i].lt; at_rsp_req = tbl[i].rsp; at_cmd_req = tbl[i].cmd; tx_done = tbl[i].done;
         tick();
         check($sformatf("t1_row%0d_lt", i), lt_gnt, tbl[i].lt_g);
         check($sformatf("t1_row%0d_rsp", i), rsp_gnt, tbl[i].rsp_g);
         check($sformatf("t1_row%0d_cmd", i), cmd_gnt, tbl[i].cmd_g);
         check($sformatf("t1_row%0d_txs", i), tx_start, tbl[i].ts);
         check($sformatf("t1_row%0d_busy", i), busy, tbl[i].bsy);
      end
      tx_done = 1'b0; at_rsp_req = 1'b0;

      // Command answered in time
      wait_gnt("t2_cmd_grant", 1'b1, 30);
      tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0; at_cmd_req = 1'b0;
      check("t2_busy_after_done", busy, 1'b1);
      repeat (15) tick();
      check("t2_busy_outstanding", busy, 1'b1);
      rsp_rcvd = 1'b1; tick(); rsp_rcvd = 1'b0;
      check("t2_cmd_ok", cmd_ok, 1'b1);
      tick();
      check("t2_cmd_ok_pulse", cmd_ok, 1'b0);
      at_cmd_req = 1'b1;
      wait_gnt("t2_regrant", 1'b1, 30);
      at_cmd_req = 1'b0;

      // No response: one retry, then fail
      clear_tally();
      run_auto(200);
      check_int("t3_retries", cnt_rty, 1);
      check_int("t3_fails", cnt_fail, 1);
      check_int("t3_cmd_grants", cnt_cmd, 1);
      check_int("t3_oks", cnt_ok, 0);
      check("t3_idle", busy, 1'b0);

      // Response on the expiry cycle
      at_cmd_req = 1'b1;
      wait_gnt("t4_cmd_grant", 1'b1, 30);
      at_cmd_req = 1'b0;
      tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      repeat (TMO - 1) tick();
      rsp_rcvd = 1'b1; tick(); rsp_rcvd = 1'b0;
      check("t4_cmd_ok", cmd_ok, 1'b1);
      check("t4_no_retry", cmd_retry, 1'b0);
      tick();
      check("t4_no_late_retry", cmd_retry, 1'b0);

      // Disconnect mid-grant with a command outstanding
      at_cmd_req = 1'b1;
      wait_gnt("t5_cmd_grant", 1'b1, 30);
      at_cmd_req = 1'b0;
      tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      lt_req = 1'b1;
      wait_gnt("t5_lt_grant", 1'b0, 30);
      tick();
      clear_tally();
      disconnect = 1'b1; at_rsp_req = 1'b1; at_cmd_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t5_disc_lt", lt_gnt, 1'b0);
         check("t5_disc_cmd", cmd_gnt, 1'b0);
         check("t5_disc_txs", tx_start, 1'b0);
         check("t5_disc_busy", busy, 1'b0);
      end
      disconnect = 1'b0; lt_req = 1'b0; at_rsp_req = 1'b0; at_cmd_req = 1'b0;
      repeat (TMO + 10) tick();
      check_int("t5_no_fail", cnt_fail, 0);
      check_int("t5_no_retry", cnt_rty, 0);

      // LT stuck high with a command waiting
      clear_tally();
      lt_req = 1'b1; at_cmd_req = 1'b1;
      run_auto(60);
      check_int("t6_first_cmd_grant_index", first_cmd, GUARD ? SLIM : -1);
      lt_req = 1'b0; at_cmd_req = 1'b0;
      run_auto(3 * TMO);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         lt_req     = ($urandom_range(0, 2) == 0);
         at_rsp_req = ($urandom_range(0, 3) == 0);
         at_cmd_req = ($urandom_range(0, 3) == 0);
         tx_done    = ((lt_gnt | rsp_gnt | cmd_gnt) && ($urandom_range(0, 2) == 0)) ||
                      ($urandom_range(0, 20) == 0);
         rsp_rcvd   = ($urandom_range(0, 25) == 0);
         disconnect = ($urandom_range(0, 150) == 0);
         tick();
      end
      lt_req = 1'b0; at_rsp_req = 1'b0; at_cmd_req = 1'b0;
      tx_done = 1'b0; rsp_rcvd = 1'b0; disconnect = 1'b0;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
